regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/brisc_pkg.sv | 6 +
 rtl/regfile_sb_if.sv | 32 +++
 rtl/regfile_sb.sv | 85 ++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// Shared core-wide parameters for the brisc pipeline.
package brisc_pkg;

    localparam int unsigned XLEN = 32;

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file read/write/alloc bus; the master issues requests, the regfile is the slave.
interface regfile_sb_if #(
    parameter int unsigned XLEN    = brisc_pkg::XLEN,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_WR  = 2
);
    localparam int unsigned ADDR_W = $clog2(REG_NUM);
    localparam int unsigned CNT_W  = $clog2(REG_NUM) + 1;

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][XLEN-1:0]   rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0]   wr_data;
    logic                          alloc_en;
    logic [ADDR_W-1:0]             alloc_addr;
    logic [CNT_W-1:0]              busy_cnt;
    logic                          alloc_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_cnt, alloc_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_cnt, alloc_err
    );

endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with a busy-bit scoreboard for long-latency destinations.
// x0 is hardwired to zero; the highest-indexed write port wins on address collisions.
module regfile_sb #(
    parameter int unsigned XLEN    = brisc_pkg::XLEN,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_WR  = 2,
    parameter int unsigned BYPASS  = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave rf
);
    localparam int unsigned ADDR_W = $clog2(REG_NUM);
    localparam int unsigned CNT_W  = $clog2(REG_NUM) + 1;

    logic [XLEN-1:0]    regs     [REG_NUM];
    logic [XLEN-1:0]    regs_nxt [REG_NUM];
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_nxt;
    logic [REG_NUM-1:0] wr_hit;
    logic [CNT_W-1:0]   busy_cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               alloc_err_q;
    logic               alloc_err_nxt;

    // Next-state: writes in port order (later ports override), then alloc overrides the clear.
    always_comb begin
        regs_nxt = regs;
        busy_nxt = busy;
        wr_hit   = '0;
        for (int w = 0; w < int'(NUM_WR); w++) begin
            if (rf.wr_en[w] && (rf.wr_addr[w] != ADDR_W'(0))) begin
                regs_nxt[rf.wr_addr[w]] = rf.wr_data[w];
                busy_nxt[rf.wr_addr[w]] = 1'b0;
                wr_hit[rf.wr_addr[w]]   = 1'b1;
            end
        end
        alloc_err_nxt = alloc_err_q;
        if (rf.alloc_en && (rf.alloc_addr != ADDR_W'(0))) begin
            busy_nxt[rf.alloc_addr] = 1'b1;
            if (busy[rf.alloc_addr] && !wr_hit[rf.alloc_addr]) begin
                alloc_err_nxt = 1'b1;
            end
        end
        cnt_nxt = '0;
        for (int i = 0; i < int'(REG_NUM); i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs[i] <= '0;
            end
            busy        <= '0;
            busy_cnt_q  <= '0;
            alloc_err_q <= 1'b0;
        end else begin
            regs        <= regs_nxt;
            busy        <= busy_nxt;
            busy_cnt_q  <= cnt_nxt;
            alloc_err_q <= alloc_err_nxt;
        end
    end

    // Read ports: stored value, optionally replaced by the winning same-cycle write.
    always_comb begin
        for (int r = 0; r < int'(NUM_RD); r++) begin
            rf.rd_data[r] = regs[rf.rd_addr[r]];
            rf.rd_busy[r] = busy[rf.rd_addr[r]];
            for (int w = 0; w < int'(NUM_WR); w++) begin
                if ((BYPASS != 0) && rf.wr_en[w] && (rf.wr_addr[w] == rf.rd_addr[r]) &&
                    (rf.rd_addr[r] != ADDR_W'(0))) begin
                    rf.rd_data[r] = rf.wr_data[w];
                end
            end
        end
    end

    assign rf.busy_cnt  = busy_cnt_q;
    assign rf.alloc_err = alloc_err_q;

endmodule
